// File: rtl/mem_pkg.sv
// Shared constants and types for the 2K x 16 memory front end.
package mem_pkg;

    localparam int MEM_AW = 11;
    localparam int MEM_DW = 32;
    localparam logic [MEM_AW-1:0] MEM_LAST_ADDR = '1;

    // Encoding of the round-robin history bit.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/rsp_slot.sv
// One-entry response buffer: loads on a grant, drains on valid&ready, holds otherwise.
module rsp_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_err,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          err,
    output logic          free
);

    // Free when empty, or when the current entry leaves on this edge.
    assign free = !valid || ready;

    // NOTE: state registers use <= so every flop samples pre-edge values; = here would order-couple the updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            err   <= load_err;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Fetch / load-store arbiter in front of the single-port 2K x 16 memory, with registered responses.
module mem_port_arb
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] i_rsp_data,
    output logic          i_rsp_err,

    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic          d_req_dlen,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    input  logic          d_rsp_ready,
    output logic [DW-1:0] d_rsp_data,
    output logic          d_rsp_err,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          mem_dlen,
    input  logic [DW-1:0] mem_q
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    grant_e last_grant, last_grant_next;
    logic   i_free, d_free;
    logic   i_elig, d_elig;
    logic   grant_i, grant_d;
    logic   i_err, d_err;
    logic [DW-1:0] i_load_data, d_load_data;

    assign i_elig = i_req_valid && i_free;
    assign d_elig = d_req_valid && d_free;

    // Reset masks the grants so no write or slot load can sneak through a reset cycle.
    assign grant_d = !rst && d_elig && (!i_elig || last_grant == GRANT_I);
    assign grant_i = !rst && i_elig && (!d_elig || last_grant == GRANT_D);

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // The memory cannot return a second word past the last address.
    assign i_err = (i_req_addr == LAST_ADDR);
    assign d_err = d_req_dlen && (d_req_addr == LAST_ADDR);

    assign mem_data = d_req_wdata;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        mem_addr = '0;
        mem_dlen = 1'b0;
        mem_we   = 1'b0;
        if (grant_d) begin
            mem_addr = d_req_addr;
            mem_dlen = d_req_dlen;
            mem_we   = d_req_we && !d_err;
        end else if (grant_i) begin
            mem_addr = i_req_addr;
            mem_dlen = 1'b1;
        end
    end

    assign i_load_data = i_err ? '0 : mem_q;
    assign d_load_data = (d_err || d_req_we) ? '0 : mem_q;

    always_comb begin
        last_grant_next = last_grant;
        if (grant_d) begin
            last_grant_next = GRANT_D;
        end else if (grant_i) begin
            last_grant_next = GRANT_I;
        end
    end

    // Starting at fetch hands the first contention to the data port.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_I;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    rsp_slot #(.DW(DW)) u_i_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_i),
        .load_data (i_load_data),
        .load_err  (i_err),
        .ready     (i_rsp_ready),
        .valid     (i_rsp_valid),
        .data      (i_rsp_data),
        .err       (i_rsp_err),
        .free      (i_free)
    );

    rsp_slot #(.DW(DW)) u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_d),
        .load_data (d_load_data),
        .load_err  (d_err),
        .ready     (d_rsp_ready),
        .valid     (d_rsp_valid),
        .data      (d_rsp_data),
        .err       (d_rsp_err),
        .free      (d_free)
    );

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a 2K x 16 memory model and a per-port response scoreboard.
module tb_mem_port_arb;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready;
    logic [10:0] i_req_addr;
    logic        i_rsp_valid, i_rsp_ready;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        d_req_valid, d_req_ready, d_req_we, d_req_dlen;
    logic [10:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid, d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [10:0] mem_addr, mem_addr_p1;
    logic [31:0] mem_data, mem_q;
    logic        mem_we, mem_dlen;

    bit   [15:0] ram     [2048];
    bit   [15:0] ref_mem [2048];
    rsp_t        iq[$];
    rsp_t        dq[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arb dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_req_addr  (i_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_err   (i_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_we    (d_req_we),
        .d_req_dlen  (d_req_dlen),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_ready (d_rsp_ready),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_dlen    (mem_dlen),
        .mem_q       (mem_q)
    );

    // Memory model: combinational read, word pair for dlen=1, write on the clock edge.
    assign mem_addr_p1 = mem_addr + 11'd1;
    assign mem_q = mem_dlen ? {ram[mem_addr], ram[mem_addr_p1]} : {16'h0000, ram[mem_addr]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_dlen) begin
                ram[mem_addr]    <= mem_data[31:16];
                ram[mem_addr_p1] <= mem_data[15:0];
            end else begin
                ram[mem_addr]    <= mem_data[15:0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: expectations from the reference memory at acceptance, compared at response handshake.
    always @(negedge clk) begin
        rsp_t        e;
        logic [10:0] a1;
        if (rst) begin
            iq.delete();
            dq.delete();
        end else begin
            if (i_rsp_valid && i_rsp_ready) begin
                check("i_rsp_pending", 32'(iq.size()), 32'd1);
                if (iq.size() > 0) begin
                    e = iq.pop_front();
                    check("i_rsp_data_sb", i_rsp_data, e.data);
                    check("i_rsp_err_sb", 32'(i_rsp_err), 32'(e.err));
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                check("d_rsp_pending", 32'(dq.size()), 32'd1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    check("d_rsp_data_sb", d_rsp_data, e.data);
                    check("d_rsp_err_sb", 32'(d_rsp_err), 32'(e.err));
                end
            end
            if (i_req_valid && i_req_ready) begin
                a1     = i_req_addr + 11'd1;
                e.err  = (i_req_addr == MEM_LAST_ADDR);
                e.data = e.err ? 32'h0 : {ref_mem[i_req_addr], ref_mem[a1]};
                iq.push_back(e);
            end
            if (d_req_valid && d_req_ready) begin
                a1    = d_req_addr + 11'd1;
                e.err = d_req_dlen && (d_req_addr == MEM_LAST_ADDR);
                if (e.err || d_req_we) e.data = 32'h0;
                else if (d_req_dlen)   e.data = {ref_mem[d_req_addr], ref_mem[a1]};
                else                   e.data = {16'h0000, ref_mem[d_req_addr]};
                dq.push_back(e);
                if (d_req_we && !e.err) begin
                    if (d_req_dlen) begin
                        ref_mem[d_req_addr] = d_req_wdata[31:16];
                        ref_mem[a1]         = d_req_wdata[15:0];
                    end else begin
                        ref_mem[d_req_addr] = d_req_wdata[15:0];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic we, input logic dlen,
                         input logic [10:0] a, input logic [31:0] wd);
        d_req_valid = v;
        d_req_we    = we;
        d_req_dlen  = dlen;
        d_req_addr  = a;
        d_req_wdata = wd;
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 11'h000; i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        set_d(1'b1, 1'b1, 1'b1, 11'h020, 32'hCAFEF00D);
        tick(); tick();

        // Reset: nothing granted, nothing written, slots empty.
        @(negedge clk);
        check("rst_i_ready", 32'(i_req_ready), 32'd0);
        check("rst_d_ready", 32'(d_req_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_i_valid", 32'(i_rsp_valid), 32'd0);
        check("rst_d_valid", 32'(d_rsp_valid), 32'd0);
        check("rst_d_data", d_rsp_data, 32'd0);
        tick();
        rst = 1'b0; i_req_valid = 1'b0; set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);

        // Seed ram[0x010..0x011] = 0x1234, 0x5678 through the store path.
        set_d(1'b1, 1'b1, 1'b1, 11'h010, 32'h12345678);
        @(negedge clk);
        check("seed_d_ready", 32'(d_req_ready), 32'd1);
        check("seed_mem_we", 32'(mem_we), 32'd1);
        tick();

        // Single fetch at 0x010: ready at N, response at N+1.
        set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        i_req_valid = 1'b1; i_req_addr = 11'h010;
        @(negedge clk);
        check("f1_i_ready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        @(negedge clk);
        check("f1_i_valid", 32'(i_rsp_valid), 32'd1);
        check("f1_i_data", i_rsp_data, 32'h12345678);
        check("f1_i_err", 32'(i_rsp_err), 32'd0);
        tick();

        // Store at 0x100 then fetch at 0x100 the next cycle returns the new data.
        set_d(1'b1, 1'b1, 1'b1, 11'h100, 32'hAABBCCDD);
        @(negedge clk);
        check("st_mem_we_n", 32'(mem_we), 32'd1);
        tick();
        set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        i_req_valid = 1'b1; i_req_addr = 11'h100;
        @(negedge clk);
        check("st_mem_we_n1", 32'(mem_we), 32'd0);
        check("st_fetch_ready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        @(negedge clk);
        check("st_fetch_data", i_rsp_data, 32'hAABBCCDD);
        tick();

        // Saturated contention: data, fetch, data, fetch; each response one cycle later.
        for (int k = 0; k <= 4; k++) begin
            i_req_valid = (k < 4); i_req_addr = 11'h010;
            set_d(k < 4, 1'b0, 1'b1, 11'h100, 32'h0);
            @(negedge clk);
            if (k < 4) begin
                check($sformatf("rr_d_ready_%0d", k), 32'(d_req_ready), 32'((k % 2) == 0));
                check($sformatf("rr_i_ready_%0d", k), 32'(i_req_ready), 32'((k % 2) == 1));
            end
            if (k > 0) begin
                check($sformatf("rr_d_valid_%0d", k), 32'(d_rsp_valid), 32'(((k - 1) % 2) == 0));
                check($sformatf("rr_i_valid_%0d", k), 32'(i_rsp_valid), 32'(((k - 1) % 2) == 1));
            end
            tick();
        end

        // Backpressure on the data response, then accept on the cycle ready rises.
        d_rsp_ready = 1'b0;
        set_d(1'b1, 1'b0, 1'b0, 11'h010, 32'h0);
        @(negedge clk);
        check("bp_first_ready", 32'(d_req_ready), 32'd1);
        tick();
        set_d(1'b1, 1'b0, 1'b1, 11'h100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_stall_ready_%0d", k), 32'(d_req_ready), 32'd0);
            check($sformatf("bp_hold_data_%0d", k), d_rsp_data, 32'h00001234);
            check($sformatf("bp_hold_valid_%0d", k), 32'(d_rsp_valid), 32'd1);
            tick();
        end
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(d_req_ready), 32'd1);
        tick();
        set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        @(negedge clk);
        check("bp_next_data", d_rsp_data, 32'hAABBCCDD);
        tick();

        // Last-address handling: 32-bit accesses rejected, 16-bit accepted.
        set_d(1'b1, 1'b1, 1'b1, MEM_LAST_ADDR, 32'h11112222);
        @(negedge clk);
        check("la_st32_ready", 32'(d_req_ready), 32'd1);
        check("la_st32_we", 32'(mem_we), 32'd0);
        tick();
        set_d(1'b1, 1'b0, 1'b1, MEM_LAST_ADDR, 32'h0);
        @(negedge clk);
        check("la_st32_err", 32'(d_rsp_err), 32'd1);
        check("la_st32_data", d_rsp_data, 32'd0);
        check("la_ld32_we", 32'(mem_we), 32'd0);
        tick();
        set_d(1'b1, 1'b1, 1'b0, MEM_LAST_ADDR, 32'h0000BEEF);
        @(negedge clk);
        check("la_ld32_err", 32'(d_rsp_err), 32'd1);
        check("la_ld32_data", d_rsp_data, 32'd0);
        check("la_st16_we", 32'(mem_we), 32'd1);
        tick();
        set_d(1'b1, 1'b0, 1'b0, MEM_LAST_ADDR, 32'h0);
        @(negedge clk);
        check("la_st16_err", 32'(d_rsp_err), 32'd0);
        tick();
        set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        i_req_valid = 1'b1; i_req_addr = MEM_LAST_ADDR;
        @(negedge clk);
        check("la_ld16_data", d_rsp_data, 32'h0000BEEF);
        check("la_ld16_err", 32'(d_rsp_err), 32'd0);
        tick();
        i_req_valid = 1'b0;
        @(negedge clk);
        check("la_fetch_err", 32'(i_rsp_err), 32'd1);
        check("la_fetch_data", i_rsp_data, 32'd0);
        tick();

        // Reset with a held fetch response; a same-cycle store must not write.
        i_rsp_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 11'h010;
        @(negedge clk);
        check("rr_hold_ready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0; rst = 1'b1;
        set_d(1'b1, 1'b1, 1'b1, 11'h200, 32'hDEADBEEF);
        @(negedge clk);
        check("rr_pre_valid", 32'(i_rsp_valid), 32'd1);
        check("rr_rst_we", 32'(mem_we), 32'd0);
        check("rr_rst_d_ready", 32'(d_req_ready), 32'd0);
        tick();
        rst = 1'b0; i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 11'h010;
        set_d(1'b1, 1'b0, 1'b1, 11'h200, 32'h0);
        @(negedge clk);
        check("rr_i_valid", 32'(i_rsp_valid), 32'd0);
        check("rr_d_valid", 32'(d_rsp_valid), 32'd0);
        check("rr_i_data", i_rsp_data, 32'd0);
        check("rr_i_err", 32'(i_rsp_err), 32'd0);
        check("rr_post_d_ready", 32'(d_req_ready), 32'd1);
        check("rr_post_i_ready", 32'(i_req_ready), 32'd0);
        tick();
        i_req_valid = 1'b0; set_d(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        @(negedge clk);
        check("rr_no_write", d_rsp_data, 32'd0);
        tick();
        @(negedge clk);

        check("i_queue_empty", 32'(iq.size()), 32'd0);
        check("d_queue_empty", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester front end for the 2K×16 single-port data/instruction memory. Accepts instruction-fetch reads and load/store requests over valid/ready handshakes, arbitrates one access per cycle onto the memory's `addr`/`data`/`we`/`dlen` pins, and returns registered responses through one-entry per-port response buffers. Sits between the CPU fetch/execute stages and the memory. Rejects 32-bit accesses at the last word address, which the memory cannot serve.

## Interface
- `AW`, default 11: word address width (16-bit words).
- `DW`, default 32: request/response data width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  fetch request present.
- `i_req_ready`  out  1  fetch request accepted this cycle when high with `i_req_valid`.
- `i_req_addr`  in  AW  fetch word address; fetch is always 32-bit (`dlen`=1).
- `i_rsp_valid` / `i_rsp_ready`  out / in  1  fetch response handshake.
- `i_rsp_data`  out  DW  `{ram[a], ram[a+1]}`.
- `i_rsp_err`  out  1  fetch was at last address.
- `d_req_valid` / `d_req_ready`  in / out  1  load/store request handshake.
- `d_req_we`  in  1  1 = store.
- `d_req_dlen`  in  1  1 = 32-bit, 0 = 16-bit (low half of data).
- `d_req_addr`  in  AW  word address.
- `d_req_wdata`  in  DW  store data.
- `d_rsp_valid` / `d_rsp_ready`  out / in  1  load/store response handshake; stores also respond.
- `d_rsp_data`  out  DW  load data; 0 for stores.
- `d_rsp_err`  out  1  32-bit access at last address.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_data`  out  DW  to memory `data`.
- `mem_we`  out  1  to memory `we`.
- `mem_dlen`  out  1  to memory `dlen`.
- `mem_q`  in  DW  memory combinational read data.

## Operation
- Port eligible when `*_req_valid` and its slot can take a response: `!*_rsp_valid | *_rsp_ready`.
- Arbitration:
  - One grant per cycle.
  - Single eligible port wins.
  - Both eligible: round-robin on a `last_grant` bit; the port not granted last wins.
  - `last_grant` updates only on a grant.
- `*_req_ready` = granted. It is combinational from valid, eligibility and `last_grant`. No combinational path from `mem_q` to any ready.
- Memory drive (combinational):
  - Granted port's addr and dlen go out; fetch forces dlen=1.
  - `mem_data` = `d_req_wdata`.
  - `mem_we` = data grant & `d_req_we` & !err.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_dlen`=0.
- err = dlen & (addr == all-ones). On err:
  - Memory write suppressed.
  - Response data 0, err 1.
- Response slot load on grant:
  - `rsp_valid`←1.
  - `rsp_data`←`mem_q` (16-bit loads: `{16'b0, q[15:0]}` as the memory presents); 0 for stores/err.
  - `rsp_err`←err.
- Slot drain: valid & ready with no new grant → `rsp_valid`←0. Data/err hold their last value.
- Slot held stable while valid & !ready.
- Reset values:
  - `*_rsp_valid`=0, `*_rsp_data`=0, `*_rsp_err`=0.
  - `last_grant`=fetch, so data wins the first contention.
  - `*_req_ready`=0, `mem_we`=0.

## Timing
- Accept at cycle N (valid&ready) → response valid from N+1. Latency 1; throughput 1/cycle per port with `rsp_ready` held high.
- Store accepted at N writes memory at edge ending N. A read granted at N+1 (either port) returns the new data.
- Contention with both ports saturated: grants alternate, so each port gets 1 access per 2 cycles.
- Drain and refill on the same edge (`rsp_valid`&`rsp_ready`&grant) → slot stays valid with new contents; no bubble.
- `rst` during an outstanding response clears it; the response is lost and the requester must reissue. `rst` overrides a same-cycle grant; no memory write occurs that cycle.
- Requests need not be held after acceptance. Unaccepted requests may change (no stability requirement enforced).

## Structure
- Shared package `mem_pkg`:
  - `MEM_AW`=11, `MEM_DW`=32.
  - `MEM_LAST_ADDR`={AW{1'b1}}.
  - `GRANT_I`/`GRANT_D` encoding of `last_grant`.
- Sub-module `rsp_slot`: one-entry response buffer with load/data/err inputs and valid/ready output. Instantiated twice (fetch, data).
- Top holds eligibility, the round-robin arbiter, err detection and the memory mux.

## Test plan
- Reset, then a single fetch at 0x010 with ram[0x010]=0x1234, ram[0x011]=0x5678 → `i_req_ready`=1 at N; `i_rsp_data`=0x12345678, err=0 at N+1.
- Store of 0xAABBCCDD, dlen=1, at 0x100 at N; fetch of 0x100 at N+1 → `mem_we`=1 only at N; fetch returns 0xAABBCCDD at N+2.
- Both ports valid every cycle after reset → data granted first, then fetch, data, fetch… Each response arrives 1 cycle after its grant.
- `d_rsp_ready`=0 for 3 cycles with `d_rsp_valid`=1 → `d_req_ready`=0 and the response is unchanged. When `d_rsp_ready` rises with a new data request pending, that request is accepted the same cycle.
- 32-bit store, then a 32-bit load, at 0x7FF → `mem_we`=0; `d_rsp_err`=1, data 0 for both. A 16-bit store at 0x7FF succeeds with err=0.
- `rst` asserted while `i_rsp_valid`=1 and `i_rsp_ready`=0 → next cycle all `rsp_valid`=0, data/err 0. The next contention is granted to data.
